// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam int c_xlen_default = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] c_f3_mul    = 3'b000;
   localparam logic [2:0] c_f3_mulh   = 3'b001;
   localparam logic [2:0] c_f3_mulhsu = 3'b010;
   localparam logic [2:0] c_f3_mulhu  = 3'b011;
   localparam logic [2:0] c_f3_div    = 3'b100;
   localparam logic [2:0] c_f3_divu   = 3'b101;
   localparam logic [2:0] c_f3_rem    = 3'b110;
   localparam logic [2:0] c_f3_remu   = 3'b111;

   function automatic logic a_is_signed(input logic [2:0] f);
      return (f == c_f3_mulh) || (f == c_f3_mulhsu) || (f == c_f3_div) || (f == c_f3_rem);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f);
      return (f == c_f3_mulh) || (f == c_f3_div) || (f == c_f3_rem);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// Module      : muldiv_if
// Description : EX-stage request / result handshake of the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
   parameter int XLEN = muldiv_pkg::c_xlen_default
);
   logic            valid_in;
   logic            ready_out;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            valid_out;
   logic            result_ready;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            busy;

   modport master (
      output valid_in, funct3, op_a, op_b, rd_in, flush, result_ready,
      input  ready_out, valid_out, result, rd_out, busy
   );

   modport slave (
      input  valid_in, funct3, op_a, op_b, rd_in, flush, result_ready,
      output ready_out, valid_out, result, rd_out, busy
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M unit: shift-add multiply, restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = c_xlen_default,
   parameter int LAT_W = $clog2(XLEN) + 1
) (
   input  logic    clk,
   input  logic    rst_n,
   muldiv_if.slave bus
);

   localparam logic [XLEN-1:0]  c_min_neg   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [LAT_W-1:0] c_last_iter = LAT_W'(XLEN);

   state_t            r_state;
   logic              r_ready;
   logic              r_busy;
   logic              r_valid;
   logic [2:0]        r_f3;
   logic [4:0]        r_rd;
   logic              r_neg;
   logic              r_special;
   logic [LAT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]   r_result;

   logic              w_accept;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_res_neg;
   logic              w_div_zero;
   logic              w_ovf;
   logic [XLEN-1:0]   w_special_val;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_trial;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quot_s;
   logic [XLEN-1:0]   w_rem_s;
   logic [XLEN-1:0]   w_final;

   assign w_accept   = bus.valid_in && r_ready && !bus.flush;
   assign w_a_neg    = a_is_signed(bus.funct3) && bus.op_a[XLEN-1];
   assign w_b_neg    = b_is_signed(bus.funct3) && bus.op_b[XLEN-1];
   assign w_mag_a    = w_a_neg ? -bus.op_a : bus.op_a;
   assign w_mag_b    = w_b_neg ? -bus.op_b : bus.op_b;
   // Remainder takes the dividend's sign; everything else is sign(a) xor sign(b).
   assign w_res_neg  = (bus.funct3 == c_f3_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
   assign w_div_zero = bus.funct3[2] && (bus.op_b == '0);
   assign w_ovf      = ((bus.funct3 == c_f3_div) || (bus.funct3 == c_f3_rem)) &&
                       (bus.op_a == c_min_neg) && (bus.op_b == '1);

   always_comb begin
      w_special_val = bus.op_a;
      if (w_div_zero) begin
         w_special_val = bus.funct3[1] ? bus.op_a : '1;
      end else if (w_ovf) begin
         w_special_val = bus.funct3[1] ? '0 : bus.op_a;
      end
   end

   // One iteration of each algorithm; r_hi/r_lo hold product or remainder/quotient.
   assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : '0)};
   assign w_div_shift = {r_hi, r_lo[XLEN-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_mcand};

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg ? -w_prod : w_prod;
   assign w_quot_s = r_neg ? -r_lo : r_lo;
   assign w_rem_s  = r_neg ? -r_hi : r_hi;

   always_comb begin
      w_final = w_prod_s[XLEN-1:0];
      case (r_f3)
         c_f3_mul:                        w_final = w_prod_s[XLEN-1:0];
         c_f3_mulh, c_f3_mulhsu,
         c_f3_mulhu:                      w_final = w_prod_s[2*XLEN-1:XLEN];
         c_f3_div, c_f3_divu:             w_final = w_quot_s;
         default:                         w_final = w_rem_s;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_f3      <= '0;
         r_rd      <= '0;
         r_neg     <= 1'b0;
         r_special <= 1'b0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_mcand   <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_f3      <= bus.funct3;
                  r_rd      <= bus.rd_in;
                  r_neg     <= w_res_neg;
                  r_special <= w_div_zero || w_ovf;
                  r_mcand   <= w_mag_b;
                  r_hi      <= '0;
                  r_lo      <= (w_div_zero || w_ovf) ? w_special_val : w_mag_a;
                  r_cnt     <= '0;
                  r_state   <= ST_CALC;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            ST_CALC: begin
               if (bus.flush) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_special || (r_cnt == c_last_iter)) begin
                  r_result <= r_special ? r_lo : w_final;
                  r_valid  <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  if (r_f3[2]) begin
                     r_hi <= w_div_trial[XLEN] ? w_div_shift[XLEN-1:0] : w_div_trial[XLEN-1:0];
                     r_lo <= {r_lo[XLEN-2:0], ~w_div_trial[XLEN]};
                  end else begin
                     r_hi <= w_mul_sum[XLEN:1];
                     r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                  end
                  r_cnt <= r_cnt + LAT_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.flush || bus.result_ready) begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_out = r_ready;
   assign bus.busy      = r_busy;
   assign bus.valid_out = r_valid;
   assign bus.result    = r_result;
   assign bus.rd_out    = r_rd;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL have parameter LAT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have valid_in  input  1  EX stage presents an M-extension op.
REQ-006 SHALL have ready_out  output  1  unit can accept an op.
REQ-007 SHALL have funct3  input  3  RV32M op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have op_a, op_b  input  XLEN  rs1/rs2 values after forwarding.
REQ-009 SHALL have rd_in  input  5  destination register tag.
REQ-010 SHALL have flush  input  1  branch/jump kill of the in-flight op.
REQ-011 SHALL have valid_out  output  1  result available.
REQ-012 SHALL have result_ready  input  1  EX/MEM register consumes result.
REQ-013 SHALL have result  output  XLEN, and rd_out  output  5, both held stable while valid_out=1.
REQ-014 SHALL have busy  output  1  to the hazard unit; high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 SHALL assert ready_out only in IDLE; accept on the edge where valid_in && ready_out && !flush.
REQ-017 On accept, SHALL latch funct3, rd_in, operand magnitudes and result sign; clear counter; enter CALC.
REQ-018 Multiply SHALL be radix-2 shift-add over a 2*XLEN product; divide SHALL be restoring, one quotient bit per cycle.
REQ-019 CALC SHALL run exactly XLEN iterations, then enter DONE; valid_out is high in the cycle after the XLEN-th CALC edge (latency XLEN+1 edges from accept).
REQ-020 Signed ops SHALL operate on magnitudes; the sign fixes up at the DONE transition (MULH: both signed; MULHSU: op_a signed only; REM sign follows dividend).
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 Divide by zero SHALL skip CALC and reach DONE on the edge after accept: DIV/DIVU -> all ones, REM/REMU -> op_a.
REQ-023 Signed overflow (op_a = min negative, op_b = -1) SHALL skip CALC: DIV -> op_a, REM -> 0.
REQ-024 In DONE, SHALL hold valid_out until result_ready=1, then return to IDLE on that edge; no back-to-back accept in DONE.
REQ-025 flush in CALC or DONE SHALL force IDLE on the next edge with no valid_out; flush in IDLE SHALL block acceptance.
REQ-026 flush SHALL take priority over result_ready and valid_in on the same edge.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, valid_out 0, busy 0, ready_out 1, result 0, rd_out 0.
REQ-028 Reset mid-CALC SHALL discard the op; the first op after release completes normally.

Structure
REQ-029 State enum, funct3 constants and the XLEN default SHALL live in shared package muldiv_pkg.
REQ-030 No sub-module is required; datapath and FSM stay in one module.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid_out exactly 33 edges after accept.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, valid_out one edge after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 flush at CALC iteration 10, then MUL 3 x 4 -> no stale valid_out; result 12 with rd_out of the second op.
REQ-036 rst_n low mid-CALC -> busy 0 and valid_out 0 immediately; result_ready held 0 in DONE keeps result stable for 5 cycles.
